// File: rtl/calc_pkg.sv
//------------------------------------------------------------------------------
// Module   : calc_pkg
// Purpose  : Shared types and constants for the sequential calculator:
//            opcode enum, FSM state enum, condition-code bit indices and a
//            helper that classifies multi-cycle opcodes.
// Config   : CALC_MULDIV_EN -- when defined, the BUSY state exists and
//            MUL/DIVU/REMU are multi-cycle operations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package calc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_CMP  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_SRA  = 4'd8,
    OP_MOV  = 4'd9,
    OP_MUL  = 4'd10,
    OP_DIVU = 4'd11,
    OP_REMU = 4'd12
  } op_e;

`ifdef CALC_MULDIV_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd2
  } state_e;
`endif

  // Bit positions inside the 4-bit condition code
  localparam int CODE_S = 3;
  localparam int CODE_Z = 2;
  localparam int CODE_C = 1;
  localparam int CODE_V = 0;

  // True for opcodes that run on the iterative multiply/divide datapath
  function automatic logic is_multi_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/calc_if.sv
//------------------------------------------------------------------------------
// Module   : calc_if
// Purpose  : Operation-in / result-out handshake bundle of the calculator.
// Ports    : in_valid/in_ready/op/a/b   - operation request channel
//            out_valid/out_ready         - result handshake
//            result/code/err             - registered result, S/Z/C/V, error
// Modports : master - producer of operations, consumer of results
//            slave  - the calculator
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface calc_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       code;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, code, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, code, err
  );

endinterface

`default_nettype wire

// File: rtl/calc_muldiv.sv
//------------------------------------------------------------------------------
// Module   : calc_muldiv
// Purpose  : Iterative unsigned shift-add multiplier and restoring divider,
//            one bit per clock, WIDTH iterations per operation.
// Ports    : clk, rst_n   - clock, asynchronous active-low reset
//            start        - load operands and begin (op = MUL/DIVU/REMU)
//            op, a, b     - opcode and operands, sampled only on start
//            done         - high during the final iteration cycle
//            prod_lo      - low half of the product
//            quot, rem    - quotient / remainder
//            hi_nonzero   - high half of the product is non-zero
//            All results reflect the value after the current iteration, so
//            they are final in the cycle where done is high.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module calc_muldiv
  import calc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             hi_nonzero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic               r_busy;
  logic               r_is_mul;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_m;      // multiplicand or divisor
  logic [2*WIDTH-1:0] r_p;      // {acc, multiplier} or {remainder, dividend/quotient}

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_trial;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_next;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_p_next;

  always_comb begin
    // Multiply step: add multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole product right one place.
    w_sum      = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_m} : '0);
    w_mul_next = {w_sum, r_p[WIDTH-1:1]};

    // Restoring divide step: shift the next dividend bit into the partial
    // remainder; subtract only if it does not go negative. Quotient bits
    // enter the low half as dividend bits leave it. A zero divisor always
    // "fits", which naturally yields quotient all-ones and remainder = a.
    w_shift    = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    w_qbit     = (w_shift >= {1'b0, r_m});
    w_trial    = w_shift[WIDTH-1:0] - r_m;
    w_rem_next = w_qbit ? w_trial : w_shift[WIDTH-1:0];
    w_div_next = {w_rem_next, r_p[WIDTH-2:0], w_qbit};

    w_p_next   = r_is_mul ? w_mul_next : w_div_next;
  end

  assign done       = r_busy && (r_cnt == LAST);
  assign prod_lo    = w_p_next[WIDTH-1:0];
  assign quot       = w_p_next[WIDTH-1:0];
  assign rem        = w_p_next[2*WIDTH-1:WIDTH];
  assign hi_nonzero = |w_p_next[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_is_mul <= 1'b0;
      r_cnt    <= '0;
      r_m      <= '0;
      r_p      <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_is_mul <= (op == OP_MUL);
      r_cnt    <= '0;
      r_m      <= (op == OP_MUL) ? a : b;
      r_p      <= {{WIDTH{1'b0}}, ((op == OP_MUL) ? b : a)};
    end else if (r_busy) begin
      r_p   <= w_p_next;
      r_cnt <= r_cnt + 1'b1;
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/calc_seq.sv
//------------------------------------------------------------------------------
// Module   : calc_seq
// Purpose  : Sequential calculator: accepts one operation over a valid/ready
//            handshake, registers result, S/Z/C/V code and error flag, and
//            holds them until the consumer takes them.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - calc_if.slave (in_valid/in_ready/op/a/b,
//                     out_valid/out_ready/result/code/err)
// Config   : CALC_MULDIV_EN -- enables MUL/DIVU/REMU via calc_muldiv and the
//            BUSY state; otherwise opcodes 10-12 report as illegal.
// Params   : WIDTH (>= 4, power of two) must match the interface WIDTH;
//            SHW is derived and must not be overridden.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module calc_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic   clk,
  input  logic   rst_n,
  calc_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  state_e           r_state;
  state_e           w_state_next;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_multi;

  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_code;
  logic             r_err;

  // Single-cycle ALU
  logic [WIDTH:0]        w_add;
  logic [WIDTH:0]        w_sub;
  logic [WIDTH:0]        w_sll;
  logic [WIDTH:0]        w_srl;
  logic signed [WIDTH:0] w_sra;
  logic [SHW-1:0]        w_sh;
  logic [WIDTH-1:0]      w_flag_src;
  logic [WIDTH-1:0]      w_alu_res;
  logic [3:0]            w_alu_code;
  logic                  w_alu_c;
  logic                  w_alu_v;
  logic                  w_alu_err;

  assign w_accept = bus.in_valid && w_in_ready;

  //----------------------------------------------------------------------------
  // Multi-cycle datapath
  //----------------------------------------------------------------------------
`ifdef CALC_MULDIV_EN
  logic             w_md_start;
  logic             w_md_done;
  logic             w_md_hi_nz;
  logic [WIDTH-1:0] w_md_prod;
  logic [WIDTH-1:0] w_md_quot;
  logic [WIDTH-1:0] w_md_rem;
  logic [3:0]       r_mop;
  logic             r_div0;
  logic [WIDTH-1:0] w_md_res;
  logic [3:0]       w_md_code;
  logic             w_md_c;
  logic             w_md_err;

  assign w_multi    = is_multi_op(bus.op);
  assign w_md_start = w_accept && w_multi;

  calc_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (w_md_start),
    .op         (bus.op),
    .a          (bus.a),
    .b          (bus.b),
    .done       (w_md_done),
    .prod_lo    (w_md_prod),
    .quot       (w_md_quot),
    .rem        (w_md_rem),
    .hi_nonzero (w_md_hi_nz)
  );

  // The submodule owns the operands; only the opcode and the divide-by-zero
  // condition are kept here to format the final result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mop  <= 4'd0;
      r_div0 <= 1'b0;
    end else if (w_md_start) begin
      r_mop  <= bus.op;
      r_div0 <= (bus.b == '0);
    end
  end

  always_comb begin
    w_md_res = '0;
    w_md_c   = 1'b0;
    w_md_err = 1'b0;
    case (r_mop)
      OP_MUL: begin
        w_md_res = w_md_prod;
        w_md_c   = w_md_hi_nz;
      end
      OP_DIVU: begin
        w_md_res = w_md_quot;
        w_md_err = r_div0;
      end
      default: begin
        w_md_res = w_md_rem;
        w_md_err = r_div0;
      end
    endcase
    w_md_code         = 4'b0000;
    w_md_code[CODE_S] = w_md_res[MSB];
    w_md_code[CODE_Z] = (w_md_res == '0);
    w_md_code[CODE_C] = w_md_c;
    w_md_code[CODE_V] = w_md_c;   // MUL reports overflow on both C and V
  end
`else
  assign w_multi = 1'b0;
`endif

  //----------------------------------------------------------------------------
  // Single-cycle ALU (evaluated on the accept cycle only)
  //----------------------------------------------------------------------------
  always_comb begin
    w_sh  = bus.b[SHW-1:0];
    w_add = {1'b0, bus.a} + {1'b0, bus.b};
    w_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    // Each shift carries one guard bit on the exit side so the last bit
    // shifted out lands there; with amount 0 the guard bit stays 0.
    w_sll = {1'b0, bus.a} << w_sh;
    w_srl = {bus.a, 1'b0} >> w_sh;
    w_sra = $signed({bus.a, 1'b0}) >>> w_sh;

    w_flag_src = '0;
    w_alu_c    = 1'b0;
    w_alu_v    = 1'b0;
    w_alu_err  = 1'b0;
    case (bus.op)
      OP_ADD: begin
        w_flag_src = w_add[MSB:0];
        w_alu_c    = w_add[WIDTH];
        w_alu_v    = (bus.a[MSB] == bus.b[MSB]) && (w_add[MSB] != bus.a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        w_flag_src = w_sub[MSB:0];
        w_alu_c    = w_sub[WIDTH];
        w_alu_v    = (bus.a[MSB] != bus.b[MSB]) && (w_sub[MSB] != bus.a[MSB]);
      end
      OP_AND: w_flag_src = bus.a & bus.b;
      OP_OR:  w_flag_src = bus.a | bus.b;
      OP_XOR: w_flag_src = bus.a ^ bus.b;
      OP_MOV: w_flag_src = bus.b;
      OP_SLL: begin
        w_flag_src = w_sll[MSB:0];
        w_alu_c    = w_sll[WIDTH];
      end
      OP_SRL: begin
        w_flag_src = w_srl[WIDTH:1];
        w_alu_c    = w_srl[0];
      end
      OP_SRA: begin
        w_flag_src = w_sra[WIDTH:1];
        w_alu_c    = w_sra[0];
      end
      default: w_alu_err = 1'b1;
    endcase

    // CMP publishes the untouched operand but flags the difference
    w_alu_res = (bus.op == OP_CMP) ? bus.a : w_flag_src;

    w_alu_code = 4'b0000;
    if (!w_alu_err) begin
      w_alu_code[CODE_S] = w_flag_src[MSB];
      w_alu_code[CODE_Z] = (w_flag_src == '0);
      w_alu_code[CODE_C] = w_alu_c;
      w_alu_code[CODE_V] = w_alu_v;
    end
  end

  //----------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
`ifdef CALC_MULDIV_EN
          w_state_next = w_multi ? ST_BUSY : ST_DONE;
`else
          w_state_next = ST_DONE;
`endif
        end
      end
`ifdef CALC_MULDIV_EN
      ST_BUSY: begin
        if (w_md_done) begin
          w_state_next = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == ST_IDLE);
    w_out_valid = (r_state == ST_DONE);
  end

  //----------------------------------------------------------------------------
  // Output registers: written on a single-cycle accept or on the last
  // iteration, otherwise held (stable throughout DONE).
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_code   <= 4'b0000;
      r_err    <= 1'b0;
    end else if (w_accept && !w_multi) begin
      r_result <= w_alu_res;
      r_code   <= w_alu_code;
      r_err    <= w_alu_err;
    end
`ifdef CALC_MULDIV_EN
    else if ((r_state == ST_BUSY) && w_md_done) begin
      r_result <= w_md_res;
      r_code   <= w_md_code;
      r_err    <= w_md_err;
    end
`endif
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.result    = r_result;
  assign bus.code      = r_code;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_calc_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_calc_seq
// Purpose  : Directed self-checking bench for calc_seq. Expected results are
//            queued when an operation is issued and compared when the DUT
//            presents it. Expectations follow CALC_MULDIV_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_calc_seq;
  import calc_pkg::*;

  localparam int W = 16;
`ifdef CALC_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  calc_if #(.WIDTH(W)) bus ();

  calc_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   code;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the DUT output against the oldest queued expectation
  task automatic pop_check(input string tag, input int n);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, 32'(n), 32'(e.lat));
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_result"}, 32'(bus.result), 32'(e.res));
      check({tag, "_code"}, 32'(bus.code), 32'(e.code));
      check({tag, "_err"}, 32'(bus.err), 32'(e.err));
    end
  endtask

  // Issue one op, scramble the inputs after accept, wait for the result
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er,
                        input logic [3:0] ec, input logic ee, input int lat);
    exp_t e;
    int   n;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.op = o;
    bus.a = x;
    bus.b = y;
    bus.in_valid = 1'b1;
    e.res = er;
    e.code = ec;
    e.err = ee;
    e.lat = lat;
    sb.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    bus.op = 4'($urandom_range(15));
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    n = 1;
    while (!bus.out_valid && n <= 64) begin
      check({tag, "_busy_no_ready"}, 32'(bus.in_ready), 32'd0);
      tick();
      n++;
    end
    pop_check(tag, n);
  endtask

  // Complete the handshake (out_ready assumed 1) and confirm return to IDLE
  task automatic finish_hs(input string tag);
    tick();
    check({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    exp_t e;

    bus.in_valid  = 1'b0;
    bus.op        = 4'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_code", 32'(bus.code), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Single-cycle ALU
    run_op("add1",  OP_ADD, 16'h0001, 16'h0002, 16'h0003, 4'b0000, 1'b0, 1); finish_hs("add1");
    run_op("sub0",  OP_SUB, 16'h0001, 16'h0001, 16'h0000, 4'b0110, 1'b0, 1); finish_hs("sub0");
    run_op("addov", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001, 1'b0, 1); finish_hs("addov");
    run_op("cmp",   OP_CMP, 16'h0005, 16'h0007, 16'h0005, 4'b1000, 1'b0, 1); finish_hs("cmp");
    run_op("sll",   OP_SLL, 16'h8001, 16'h0001, 16'h0002, 4'b0010, 1'b0, 1); finish_hs("sll");
    run_op("sra",   OP_SRA, 16'h8008, 16'h0004, 16'hF800, 4'b1010, 1'b0, 1); finish_hs("sra");
    run_op("srl0",  OP_SRL, 16'h8001, 16'h0010, 16'h8001, 4'b1000, 1'b0, 1); finish_hs("srl0");
    run_op("xor",   OP_XOR, 16'hFFFF, 16'hFFFF, 16'h0000, 4'b0100, 1'b0, 1); finish_hs("xor");
    run_op("mov",   OP_MOV, 16'hABCD, 16'h1234, 16'h1234, 4'b0000, 1'b0, 1); finish_hs("mov");
    run_op("ill14", 4'd14,  16'h1111, 16'h2222, 16'h0000, 4'b0000, 1'b1, 1); finish_hs("ill14");

    // Multi-cycle ops (illegal single-cycle when the feature is absent)
    run_op("mulov", OP_MUL,  16'h0100, 16'h0100, 16'h0000, MD ? 4'b0111 : 4'b0000,
           !MD, MD ? 17 : 1); finish_hs("mulov");
    run_op("mul",   OP_MUL,  16'h0003, 16'h0005, MD ? 16'h000F : 16'h0000, 4'b0000,
           !MD, MD ? 17 : 1); finish_hs("mul");
    run_op("div0",  OP_DIVU, 16'h0007, 16'h0000, MD ? 16'hFFFF : 16'h0000,
           MD ? 4'b1000 : 4'b0000, 1'b1, MD ? 17 : 1); finish_hs("div0");
    run_op("divu",  OP_DIVU, 16'h0064, 16'h0007, MD ? 16'h000E : 16'h0000, 4'b0000,
           !MD, MD ? 17 : 1); finish_hs("divu");
    run_op("remu",  OP_REMU, 16'h0007, 16'h0002, MD ? 16'h0001 : 16'h0000, 4'b0000,
           !MD, MD ? 17 : 1); finish_hs("remu");

    // Backpressure: result held stable while out_ready is low
    bus.out_ready = 1'b0;
    run_op("bp", OP_ADD, 16'h00F0, 16'h0F10, 16'h1000, 4'b0000, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_result", 32'(bus.result), 32'h1000);
      check("bp_code", 32'(bus.code), 32'd0);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    finish_hs("bp");

    // in_valid held through the handshake cycle: not taken until next cycle
    run_op("tp1", OP_ADD, 16'h0002, 16'h0003, 16'h0005, 4'b0000, 1'b0, 1);
    bus.op = OP_ADD;
    bus.a = 16'h0004;
    bus.b = 16'h0004;
    bus.in_valid = 1'b1;
    e.res = 16'h0008;
    e.code = 4'b0000;
    e.err = 1'b0;
    e.lat = 1;
    sb.push_back(e);
    tick();
    check("tp_hs_valid", 32'(bus.out_valid), 32'd0);
    check("tp_hs_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    pop_check("tp2", 1);
    finish_hs("tp2");

    // Reset four cycles into a DIVU (or while holding its result)
    bus.out_ready = 1'b0;
    bus.op = OP_DIVU;
    bus.a = 16'h1234;
    bus.b = 16'h0003;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_result", 32'(bus.result), 32'd0);
    check("mrst_code", 32'(bus.code), 32'd0);
    check("mrst_err", 32'(bus.err), 32'd0);
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      seen = seen | bus.out_valid;
    end
    check("mrst_no_stale", 32'(seen), 32'd0);

    run_op("post", OP_OR, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000, 1'b0, 1);
    finish_hs("post");

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/calc_seq.md
# calc_seq

Parametrised sequential successor to the combinational 16-bit calculator in the CPU datapath. It accepts one operation at a time over a valid/ready handshake and registers the result and S/Z/C/V condition code. It adds iterative multiply, unsigned divide and remainder, plus output backpressure. It sits between decode and writeback and stalls the front end through `in_ready`.

## Interface
- `WIDTH`, default 16: operand/result width; ≥ 4, power of two.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width (derived, do not override).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operation presented.
- `in_ready`  out  1  block can accept; equals (state == IDLE).
- `op`  in  4  opcode: 0 ADD, 1 SUB, 2 CMP, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA, 9 MOV, 10 MUL, 11 DIVU, 12 REMU, 13–15 illegal.
- `a`, `b`  in  WIDTH  operands.
- `out_valid`  out  1  result/code/err valid.
- `out_ready`  in  1  consumer takes result.
- `result`  out  WIDTH  registered result.
- `code`  out  4  registered flags: [3] S, [2] Z, [1] C, [0] V.
- `err`  out  1  illegal opcode or divide by zero.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE → DONE on accept of a single-cycle op.
  - IDLE → BUSY on accept of MUL, DIVU or REMU.
  - BUSY → DONE after WIDTH iterations.
  - DONE → IDLE when `out_ready` = 1.
- Accept = `in_valid && in_ready`. `op`, `a` and `b` are captured at accept and never sampled again.
- ADD: `a + b`. C = carry out. V = signed overflow.
- SUB: `a + ~b + 1`. C = carry out (1 = no borrow). V = signed overflow.
- CMP: flags as SUB; `result` = `a` (unchanged operand).
- AND/OR/XOR/MOV(=`b`): C = V = 0.
- Shifts: amount is `b[SHW-1:0]`. C = last bit shifted out, and C = 0 for amount 0. V = 0. SRA replicates the MSB.
- MUL: unsigned shift-add producing a 2·WIDTH product. `result` = low half. C = V = 1 iff the high half ≠ 0.
- DIVU/REMU: restoring division, one quotient bit per cycle. `result` = quotient or remainder. C = V = 0.
- Divide by zero: quotient = all ones, remainder = `a`, `err` = 1.
- Illegal op: `result` = 0, `code` = 0000, `err` = 1, single-cycle latency.
- S = `result[WIDTH-1]` and Z = (`result` == 0) for every op, including CMP, which uses the difference.
- In DONE, `result`, `code` and `err` hold stable until the handshake completes.

## Timing
- Reset values: state IDLE, `out_valid` 0, `result` 0, `code` 0000, `err` 0. `in_ready` is 1 as soon as the FSM is in IDLE.
- Single-cycle op accepted at edge N: `out_valid` = 1 after edge N+1.
- MUL/DIVU/REMU accepted at edge N: `out_valid` = 1 after edge N+WIDTH+1. `in_ready` = 0 throughout.
- No accept while in DONE. `in_valid` in the same cycle the handshake completes is not accepted; its earliest accept is the next cycle.
- Throughput: one single-cycle op per 2 clocks when `out_ready` is held at 1.
- Reset asserted mid-BUSY or in DONE: the operation is dropped, all outputs take reset values immediately, and no result is produced.

## Configuration
- `CALC_MULDIV_EN` defined: MUL, DIVU and REMU are implemented as above.
- Not defined:
  - opcodes 10–12 are treated as illegal (`result` 0, `err` 1, single cycle);
  - the BUSY state and the iterative datapath are not compiled.

## Structure
- Package `calc_pkg` holds:
  - the opcode enum;
  - the FSM state enum;
  - flag bit-index constants `CODE_S`, `CODE_Z`, `CODE_C`, `CODE_V`.
- Sub-module `calc_muldiv`:
  - ports: start, op, a, b, done, product-low / quotient / remainder, hi_nonzero;
  - instantiated only under `CALC_MULDIV_EN`.
- Top level contains the FSM, the single-cycle ALU and the output registers.

## Test plan
- ADD `a`=0x0001, `b`=0x0002 → `result` 0x0003, `code` 0000, `out_valid` exactly one cycle after accept.
- SUB 0x0001 − 0x0001 → 0x0000, `code` 0110. ADD 0x7FFF + 0x0001 → 0x8000, `code` 1001.
- MUL 0x0100 × 0x0100 → 0x0000, `code` 0111, `out_valid` 17 cycles after accept. MUL 0x0003 × 0x0005 → 0x000F, `code` 0000.
- DIVU 0x0007 / 0x0000 → 0xFFFF, `err` 1. REMU 0x0007 / 0x0002 → 0x0001, `err` 0. Opcode 14 → 0x0000, `err` 1.
- Hold `out_ready` = 0 for 5 cycles after a result appears → `result`/`code` stable, `in_ready` 0. Raise `out_ready` → IDLE next cycle.
- Drop `rst_n` 4 cycles into a DIVU → `out_valid` 0, `result` 0, `in_ready` 1. No stale result after reset releases.
